// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle: holding-register data, valid/ready and error pulses.
// The parity_err pulse exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    input  rx_ready,
    output rx_data, rx_valid, frame_err, overrun
`ifdef UART_RX_PARITY_EN
    , parity_err
`endif
  );

  modport slave (
    output rx_ready,
    input  rx_data, rx_valid, frame_err, overrun
`ifdef UART_RX_PARITY_EN
    , parity_err
`endif
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver (start, LSB-first data, optional even parity via UART_RX_PARITY_EN, stop); word valid 1 clk
// after the stop-bit centre sample; a word completing while the holding register is full is dropped with overrun.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD       = 9600,
  parameter int SYS_CLK    = 12000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         rx_wire,
  uart_rx_if.master    bus
);

  localparam int DIV_RAW = SYS_CLK / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rxs;
  logic                 rxs_d;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        samp_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                 par_acc;
  logic                 par_bad;
`endif

  logic tick;
  logic half_pt;
  logic full_pt;

  assign tick    = (div_cnt == DW'(DIV - 1));
  assign half_pt = tick && (samp_cnt == SW'(OVERSAMPLE / 2 - 1));
  assign full_pt = tick && (samp_cnt == SW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rx_meta      <= 1'b1;
      rxs          <= 1'b1;
      rxs_d        <= 1'b1;
      div_cnt      <= '0;
      samp_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc      <= 1'b0;
      par_bad      <= 1'b0;
      bus.parity_err <= 1'b0;
`endif
    end else begin
      rx_meta       <= rx_wire;
      rxs           <= rx_meta;
      rxs_d         <= rxs;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) samp_cnt <= samp_cnt + 1'b1;

      if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;

      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // Restart the divider on the edge so every sample lands mid-bit.
            if (rxs_d && !rxs) begin
              state    <= START;
              div_cnt  <= '0;
              samp_cnt <= '0;
            end
          end
          START: begin
            if (half_pt) begin
              samp_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
              par_acc  <= 1'b0;
`endif
            end
          end
          DATA: begin
            if (full_pt) begin
              samp_cnt <= '0;
              shift    <= {rxs, shift[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
              par_acc  <= par_acc ^ rxs;
              if (bit_cnt == 4'(DATA_BITS - 1)) state <= PARITY;
`else
              if (bit_cnt == 4'(DATA_BITS - 1)) state <= STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (full_pt) begin
              samp_cnt <= '0;
              par_bad  <= par_acc ^ rxs;
              state    <= STOP;
            end
          end
`endif
          STOP: begin
            if (full_pt) begin
              samp_cnt <= '0;
              if (!rxs) begin
                bus.frame_err <= 1'b1;
                state         <= BREAK;
              end else begin
                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (par_bad) begin
                  bus.parity_err <= 1'b1;
                end else
`endif
                if (!bus.rx_valid || bus.rx_ready) begin
                  bus.rx_data  <= shift;
                  bus.rx_valid <= 1'b1;
                end else begin
                  bus.overrun <= 1'b1;
                end
              end
            end
          end
          BREAK: begin
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected words; a negedge monitor pops on accept.
module tb_uart_rx;
  localparam int SYS_CLK = 2000000;
  localparam int BIT     = 208;  // 2e6 / (9600*16) = 13 clks per tick, 16 ticks per bit

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic enable  = 1'b0;
  logic rx_wire = 1'b1;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .DATA_BITS (8),
    .BAUD      (9600),
    .SYS_CLK   (SYS_CLK),
    .OVERSAMPLE(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .rx_wire(rx_wire),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int pe_cnt   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (bus.parity_err) pe_cnt++;
`endif
      if (bus.frame_err || bus.overrun)
        check("pulse_exclusive", int'(bus.frame_err & bus.overrun), 0);
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", bus.rx_data);
        end else begin
          check("rx_data", int'(bus.rx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_wire = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_byte_bad_par(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~^d);
    send_bit(1'b1);
  endtask
`endif

  task automatic idle(input int n);
    rx_wire = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int fe0, ov0, pe0;
    bus.rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_rx_data", int'(bus.rx_data), 0);
    check("reset_rx_valid", int'(bus.rx_valid), 0);
    check("reset_frame_err", int'(bus.frame_err), 0);
    check("reset_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    enable = 1'b1;
    idle(BIT);

    // 1: plain word, consumer always ready
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(BIT / 4);
    check("t1_drained", exp_q.size(), 0);
    check("t1_valid_cleared", int'(bus.rx_valid), 0);
    check("t1_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // 2: short low glitch is rejected, next word still received
    fe0 = fe_cnt;
    rx_wire = 1'b0;
    repeat (30) @(negedge clk);
    idle(2 * BIT);
    check("t2_glitch_no_word", int'(bus.rx_valid), 0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    idle(BIT / 4);
    check("t2_drained", exp_q.size(), 0);
    check("t2_no_frame_err", fe_cnt - fe0, 0);

    // 3: bad stop bit, line held low (break), then recovery
    fe0 = fe_cnt;
    send_byte(8'h55, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    idle(BIT);
    check("t3_frame_err_once", fe_cnt - fe0, 1);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle(BIT / 4);
    check("t3_drained", exp_q.size(), 0);

    // 4: consumer stalled, second word overruns
    ov0 = ov_cnt;
    bus.rx_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(BIT / 4);
    check("t4_valid_held", int'(bus.rx_valid), 1);
    check("t4_data_held", int'(bus.rx_data), 8'h11);
    check("t4_overrun_once", ov_cnt - ov0, 1);
    exp_q.push_back(8'h11);
    @(posedge clk);
    #1 bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_valid_cleared", int'(bus.rx_valid), 0);
    check("t4_drained", exp_q.size(), 0);

    // 5: reset in the middle of data bit 4 of 0xF0
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx_wire = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_rst_rx_data", int'(bus.rx_data), 0);
    check("t5_rst_rx_valid", int'(bus.rx_valid), 0);
    check("t5_rst_frame_err", int'(bus.frame_err), 0);
    check("t5_rst_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    idle(2 * BIT);
    check("t5_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    idle(BIT / 4);
    check("t5_drained", exp_q.size(), 0);

    // enable dropped mid-frame: frame discarded silently
    fe0 = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    enable = 1'b0;
    rx_wire = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    idle(12 * BIT);
    check("en_no_frame_err", fe_cnt - fe0, 0);
    check("en_no_word", int'(bus.rx_valid), 0);
    exp_q.push_back(8'h6E);
    send_byte(8'h6E, 1'b1);
    idle(BIT / 4);
    check("en_drained", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    // 6: even parity good then bad
    pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_byte(8'h07, 1'b1);
    idle(BIT / 4);
    check("t6_good_drained", exp_q.size(), 0);
    check("t6_good_no_perr", pe_cnt - pe0, 0);
    send_byte_bad_par(8'h07);
    idle(BIT / 4);
    check("t6_parity_err_once", pe_cnt - pe0, 1);
    check("t6_bad_no_word", int'(bus.rx_valid), 0);
`else
    pe0 = pe_cnt;
    check("no_parity_pulses", pe_cnt - pe0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
